// File: rtl/icache_dm.sv
// Direct-mapped, word-granular instruction cache with bypass for data and
// uncacheable traffic, write-hit invalidation and sequential flush.
module icache_dm #(
   parameter int                    NUM_LINES  = 64,
   parameter int                    ADDR_WIDTH = 34,
   parameter logic [ADDR_WIDTH-1:0] CACHE_BASE = 34'h0_8000_0000,
   parameter logic [ADDR_WIDTH-1:0] CACHE_MASK = 34'h3_F000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_valid,
   output logic                  cpu_ready,
   input  logic [3:0]            cpu_wstrb,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [31:0]           cpu_wdata,
   output logic [31:0]           cpu_rdata,
   output logic                  cpu_access_fault,
   input  logic                  is_instruction,
   input  logic                  icache_flush,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic [3:0]            mem_wstrb,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_access_fault
);

   localparam int IDX = $clog2(NUM_LINES);
   localparam int WW  = ADDR_WIDTH - 2;
   localparam int TW  = ADDR_WIDTH - IDX - 2;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      REFILL,
      BYPASS,
      FLUSH
   } state_t;

   state_t               state;
   logic [NUM_LINES-1:0] valid;
   logic                 flush_pending;
   logic [IDX-1:0]       ctr;
   logic [WW-1:0]        req_word;
   logic                 ready_q;
   logic                 fault_q;
   logic [31:0]          rdata_q;

   logic [TW-1:0]        tag_arr [NUM_LINES];
   logic [31:0]          data_arr [NUM_LINES];
   logic [TW-1:0]        rd_tag;
   logic [31:0]          rd_data;

   logic [WW-1:0]        cpu_word;
   logic [IDX-1:0]       cpu_idx;
   logic [IDX-1:0]       req_idx;
   logic [TW-1:0]        req_tag;
   logic                 accept;
   logic                 cacheable;
   logic                 fetch;
   logic                 line_match;
   logic                 hit;
   logic                 flush_req;
   logic                 unused_addr;

   assign cpu_word    = cpu_addr[ADDR_WIDTH-1:2];
   assign cpu_idx     = cpu_word[IDX-1:0];
   assign req_idx     = req_word[IDX-1:0];
   assign req_tag     = req_word[WW-1:IDX];
   assign unused_addr = ^cpu_addr[1:0];

   // ready_q blocks re-accepting the request the core still holds during its ready pulse
   assign accept    = (state == IDLE) & cpu_valid & ~flush_pending & ~ready_q;
   assign cacheable = (cpu_addr & CACHE_MASK) == CACHE_BASE;
   assign fetch     = is_instruction & (cpu_wstrb == 4'h0) & cacheable;
   assign flush_req = flush_pending | icache_flush;

   assign line_match = valid[req_idx] & (rd_tag == req_tag);
   assign hit        = (state == LOOKUP) & line_match;

   assign cpu_ready        = ready_q | hit;
   assign cpu_rdata        = hit ? rd_data : rdata_q;
   assign cpu_access_fault = fault_q;

   // tag/data arrays: sync read on accept, write on a clean refill
   always_ff @(posedge clk) begin
      if (accept) begin
         rd_tag  <= tag_arr[cpu_idx];
         rd_data <= data_arr[cpu_idx];
      end
      if (state == REFILL && mem_ready && !mem_access_fault) begin
         tag_arr[req_idx]  <= req_tag;
         data_arr[req_idx] <= mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         valid         <= '0;
         flush_pending <= 1'b0;
         ctr           <= '0;
         req_word      <= '0;
         ready_q       <= 1'b0;
         fault_q       <= 1'b0;
         rdata_q       <= '0;
         mem_valid     <= 1'b0;
         mem_wstrb     <= '0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
      end else begin
         ready_q <= 1'b0;
         fault_q <= 1'b0;
         if (icache_flush && state != FLUSH)
            flush_pending <= 1'b1;

         unique case (state)
            IDLE: begin
               if (accept) begin
                  req_word <= cpu_word;
                  if (fetch) begin
                     state <= LOOKUP;
                  end else begin
                     state     <= BYPASS;
                     mem_valid <= 1'b1;
                     mem_addr  <= {cpu_word, 2'b00};
                     mem_wstrb <= cpu_wstrb;
                     mem_wdata <= cpu_wdata;
                  end
               end else if (flush_req) begin
                  state         <= FLUSH;
                  ctr           <= '0;
                  flush_pending <= 1'b0;
               end
            end

            LOOKUP: begin
               if (line_match) begin
                  state         <= flush_req ? FLUSH : IDLE;
                  ctr           <= '0;
                  flush_pending <= 1'b0;
               end else begin
                  state     <= REFILL;
                  mem_valid <= 1'b1;
                  mem_addr  <= {req_word, 2'b00};
                  mem_wstrb <= 4'h0;
               end
            end

            REFILL: begin
               if (mem_ready) begin
                  if (!mem_access_fault)
                     valid[req_idx] <= 1'b1;
                  mem_valid     <= 1'b0;
                  ready_q       <= 1'b1;
                  rdata_q       <= mem_rdata;
                  fault_q       <= mem_access_fault;
                  state         <= flush_req ? FLUSH : IDLE;
                  ctr           <= '0;
                  flush_pending <= 1'b0;
               end
            end

            BYPASS: begin
               if (mem_ready) begin
                  // stores drop a matching cached word so modified code is refetched
                  if (mem_wstrb != 4'h0 && line_match)
                     valid[req_idx] <= 1'b0;
                  mem_valid     <= 1'b0;
                  ready_q       <= 1'b1;
                  rdata_q       <= mem_rdata;
                  fault_q       <= mem_access_fault;
                  state         <= flush_req ? FLUSH : IDLE;
                  ctr           <= '0;
                  flush_pending <= 1'b0;
               end
            end

            FLUSH: begin
               valid[ctr] <= 1'b0;
               if (icache_flush)
                  ctr <= '0;
               else if (ctr == IDX'(NUM_LINES - 1))
                  state <= IDLE;
               else
                  ctr <= ctr + 1'b1;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus random traffic
// against a line-level reference model and a behavioural memory slave.
module tb_icache_dm;

   localparam int          NL   = 64;
   localparam logic [33:0] BASE = 34'h0_8000_0000;
   localparam logic [33:0] MASK = 34'h3_F000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_valid;
   logic        cpu_ready;
   logic [3:0]  cpu_wstrb;
   logic [33:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_access_fault;
   logic        is_instruction;
   logic        icache_flush;
   logic        mem_valid;
   logic        mem_ready;
   logic [3:0]  mem_wstrb;
   logic [33:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_access_fault;

   int errors = 0;
   int checks = 0;

   bit [31:0] mem_m [bit [31:0]];
   int        txn_cnt = 0;
   int        resp_delay = 0;
   bit        inject_fault = 0;
   int        wait_cnt = 0;

   // reference model: which word address each line holds, and its data
   bit        mv [NL];
   bit [31:0] mline [NL];
   bit [31:0] mdat [NL];

   icache_dm #(.NUM_LINES(NL)) dut (
      .clk(clk),
      .reset(reset),
      .cpu_valid(cpu_valid),
      .cpu_ready(cpu_ready),
      .cpu_wstrb(cpu_wstrb),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata),
      .cpu_access_fault(cpu_access_fault),
      .is_instruction(is_instruction),
      .icache_flush(icache_flush),
      .mem_valid(mem_valid),
      .mem_ready(mem_ready),
      .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_access_fault(mem_access_fault)
   );

   always #5 clk = ~clk;

   function automatic bit [31:0] rd_mem(input bit [31:0] wa);
      if (mem_m.exists(wa))
         return mem_m[wa];
      return wa * 32'h9E37_79B1 + 32'h1234_5678;
   endfunction

   // memory slave: answers after resp_delay cycles with a one-cycle mem_ready
   always @(negedge clk) begin
      bit [31:0] wa;
      bit [31:0] w;
      if (reset) begin
         mem_ready = 1'b0;
         mem_access_fault = 1'b0;
         wait_cnt = 0;
      end else if (mem_ready) begin
         mem_ready = 1'b0;
         mem_access_fault = 1'b0;
      end else if (mem_valid) begin
         if (wait_cnt >= resp_delay) begin
            wa = mem_addr[33:2];
            mem_rdata = rd_mem(wa);
            mem_access_fault = inject_fault;
            mem_ready = 1'b1;
            if (mem_wstrb != 4'h0 && !inject_fault) begin
               w = rd_mem(wa);
               for (int b = 0; b < 4; b++)
                  if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
               mem_m[wa] = w;
            end
            txn_cnt++;
            wait_cnt = 0;
         end else begin
            wait_cnt++;
         end
      end
   end

   task automatic do_req(input bit instr, input logic [33:0] a,
                         input logic [3:0] ws, input logic [31:0] wd,
                         output logic [31:0] rd, output logic flt,
                         output int lat, output int txns,
                         output bit tmo, output logic extra);
      int t0;
      t0 = txn_cnt;
      is_instruction = instr;
      cpu_addr = a;
      cpu_wstrb = ws;
      cpu_wdata = wd;
      cpu_valid = 1'b1;
      lat = 0;
      tmo = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         lat++;
         if (cpu_ready) begin
            tmo = 1'b0;
            break;
         end
      end
      rd = cpu_rdata;
      flt = cpu_access_fault;
      cpu_valid = 1'b0;
      cpu_wstrb = 4'h0;
      @(negedge clk);
      extra = cpu_ready;
      txns = txn_cnt - t0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      cpu_valid = 0; cpu_wstrb = 0; cpu_addr = 0; cpu_wdata = 0;
      is_instruction = 0; icache_flush = 0;
      mem_ready = 0; mem_rdata = 0; mem_access_fault = 0;
      apply_reset();
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_cpu_ready got=%b exp=0", cpu_ready); end
      checks++; if (cpu_access_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got=%b exp=0", cpu_access_fault); end
      checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", cpu_rdata); end
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got=%b exp=0", mem_valid); end
      checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL rst_mem_wstrb got=%h exp=0", mem_wstrb); end
      checks++; if (mem_addr !== 34'h0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
   endtask

   task automatic test_cold_fetch();
      logic [31:0] rd; logic flt; int lat; int tx; bit tmo; logic ex;
      mem_m[32'h2000_0040] = 32'h0000_0013;
      resp_delay = 0;
      do_req(1, 34'h0_8000_0100, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
      checks++; if (tmo) begin errors++; $display("FAIL cold_timeout got=timeout exp=ready"); end
      checks++; if (rd !== 32'h13) begin errors++; $display("FAIL cold_rdata got=%h exp=00000013", rd); end
      checks++; if (tx !== 1) begin errors++; $display("FAIL cold_txns got=%0d exp=1", tx); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL cold_latency got=%0d exp=3", lat); end
      checks++; if (ex !== 1'b0) begin errors++; $display("FAIL cold_single_ready got=%b exp=0", ex); end
      do_req(1, 34'h0_8000_0100, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
      checks++; if (rd !== 32'h13) begin errors++; $display("FAIL hit_rdata got=%h exp=00000013", rd); end
      checks++; if (tx !== 0) begin errors++; $display("FAIL hit_txns got=%0d exp=0", tx); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL hit_latency got=%0d exp=1", lat); end
      checks++; if (ex !== 1'b0) begin errors++; $display("FAIL hit_single_ready got=%b exp=0", ex); end
   endtask

   task automatic test_load_bypass();
      logic [31:0] rd; logic flt; int lat; int tx; bit tmo; logic ex;
      do_req(0, 34'h0_8000_0100, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
      checks++; if (tx !== 1) begin errors++; $display("FAIL load_txns got=%0d exp=1", tx); end
      checks++; if (rd !== 32'h13) begin errors++; $display("FAIL load_rdata got=%h exp=00000013", rd); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency got=%0d exp=2", lat); end
      do_req(1, 34'h0_8000_0100, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
      checks++; if (tx !== 0) begin errors++; $display("FAIL load_keeps_line got=%0d exp=0", tx); end
   endtask

   task automatic test_store_invalidate();
      logic [31:0] rd; logic flt; int lat; int tx; bit tmo; logic ex;
      do_req(0, 34'h0_8000_0100, 4'hF, 32'hDEAD_BEEF, rd, flt, lat, tx, tmo, ex);
      checks++; if (tx !== 1) begin errors++; $display("FAIL store_txns got=%0d exp=1", tx); end
      do_req(1, 34'h0_8000_0100, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
      checks++; if (tx !== 1) begin errors++; $display("FAIL store_inval_miss got=%0d exp=1", tx); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_refill got=%h exp=deadbeef", rd); end
      do_req(1, 34'h0_8000_0100, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
      checks++; if (tx !== 0) begin errors++; $display("FAIL store_rehit got=%0d exp=0", tx); end
   endtask

   task automatic test_uncacheable_fault();
      logic [31:0] rd; logic flt; int lat; int tx; bit tmo; logic ex;
      logic [31:0] exp_rd;
      exp_rd = rd_mem(32'h0400_0000);
      for (int k = 0; k < 2; k++) begin
         do_req(1, 34'h0_1000_0000, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
         checks++; if (tx !== 1) begin errors++; $display("FAIL uncach_txns[%0d] got=%0d exp=1", k, tx); end
         checks++; if (rd !== exp_rd) begin errors++; $display("FAIL uncach_rdata[%0d] got=%h exp=%h", k, rd, exp_rd); end
      end
      inject_fault = 1;
      do_req(1, 34'h0_8000_0200, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
      inject_fault = 0;
      checks++; if (flt !== 1'b1) begin errors++; $display("FAIL fault_fwd got=%b exp=1", flt); end
      checks++; if (tx !== 1) begin errors++; $display("FAIL fault_txns got=%0d exp=1", tx); end
      do_req(1, 34'h0_8000_0200, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
      checks++; if (tx !== 1) begin errors++; $display("FAIL fault_nofill got=%0d exp=1", tx); end
      checks++; if (flt !== 1'b0) begin errors++; $display("FAIL fault_clear got=%b exp=0", flt); end
   endtask

   task automatic test_flush_during_refill();
      logic [31:0] rd; logic flt; int lat; int tx; bit tmo; logic ex;
      logic [33:0] fa [3];
      int n; int busy; bit seen;
      fa[0] = 34'h0_8000_0400; fa[1] = 34'h0_8000_0404; fa[2] = 34'h0_8000_0408;
      for (int k = 0; k < 3; k++) begin
         do_req(1, fa[k], 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
         checks++; if (tx !== 1) begin errors++; $display("FAIL flush_fill[%0d] got=%0d exp=1", k, tx); end
      end
      resp_delay = 6;
      is_instruction = 1; cpu_addr = 34'h0_8000_0500; cpu_wstrb = 0; cpu_valid = 1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = mem_valid; end
      icache_flush = 1;
      @(negedge clk);
      icache_flush = 0;
      seen = cpu_ready;
      for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = cpu_ready; end
      checks++; if (!seen) begin errors++; $display("FAIL flush_refill_done got=timeout exp=ready"); end
      checks++; if (cpu_rdata !== rd_mem(32'h2000_0140)) begin errors++; $display("FAIL flush_refill_rdata got=%h exp=%h", cpu_rdata, rd_mem(32'h2000_0140)); end
      cpu_valid = 0;
      resp_delay = 0;
      @(negedge clk);
      n = 1; busy = 0;
      cpu_addr = fa[0]; cpu_valid = 1;
      while (!mem_valid && n < 300) begin
         busy += int'(cpu_ready);
         @(negedge clk);
         n++;
      end
      checks++; if (n !== NL + 2) begin errors++; $display("FAIL flush_duration got=%0d exp=%0d", n, NL + 2); end
      checks++; if (busy !== 0) begin errors++; $display("FAIL flush_quiet got=%0d exp=0", busy); end
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = cpu_ready; end
      cpu_valid = 0;
      @(negedge clk);
      for (int k = 1; k < 3; k++) begin
         do_req(1, fa[k], 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
         checks++; if (tx !== 1) begin errors++; $display("FAIL flush_miss[%0d] got=%0d exp=1", k, tx); end
      end
   endtask

   task automatic test_conflict();
      logic [31:0] rd; logic flt; int lat; int tx; bit tmo; logic ex;
      do_req(1, 34'h0_8000_0000, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
      do_req(1, 34'h0_8000_0100, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
      checks++; if (tx !== 1) begin errors++; $display("FAIL conflict_second got=%0d exp=1", tx); end
      do_req(1, 34'h0_8000_0000, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
      checks++; if (tx !== 1) begin errors++; $display("FAIL conflict_evict got=%0d exp=1", tx); end
      checks++; if (rd !== rd_mem(32'h2000_0000)) begin errors++; $display("FAIL conflict_rdata got=%h exp=%h", rd, rd_mem(32'h2000_0000)); end
   endtask

   task automatic test_reset_mid_refill();
      logic [31:0] rd; logic flt; int lat; int tx; bit tmo; logic ex;
      bit seen;
      do_req(1, 34'h0_8000_0100, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
      do_req(1, 34'h0_8000_0100, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
      checks++; if (tx !== 0) begin errors++; $display("FAIL rmid_precached got=%0d exp=0", tx); end
      resp_delay = 50;
      is_instruction = 1; cpu_addr = 34'h0_8000_0300; cpu_wstrb = 0; cpu_valid = 1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = mem_valid; end
      checks++; if (!seen) begin errors++; $display("FAIL rmid_refill_start got=timeout exp=mem_valid"); end
      reset = 1;
      cpu_valid = 0;
      @(negedge clk);
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rmid_mem_valid got=%b exp=0", mem_valid); end
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rmid_cpu_ready got=%b exp=0", cpu_ready); end
      @(negedge clk);
      reset = 0;
      resp_delay = 0;
      @(negedge clk);
      do_req(1, 34'h0_8000_0100, 4'h0, 32'h0, rd, flt, lat, tx, tmo, ex);
      checks++; if (tx !== 1) begin errors++; $display("FAIL rmid_lines_cleared got=%0d exp=1", tx); end
   endtask

   task automatic test_random();
      logic [31:0] rd; logic flt; int lat; int tx; bit tmo; logic ex;
      logic [33:0] a; logic [3:0] ws; logic [31:0] wd; bit instr;
      bit [31:0] wa; int li; int d; int k;
      bit do_fetch; bit fi;
      int e_tx; int e_lat; logic [31:0] e_rd; logic e_flt;
      apply_reset();
      for (int i = 0; i < NL; i++) mv[i] = 0;
      for (int it = 0; it < 200; it++) begin
         if ($urandom_range(0, 24) == 0) begin
            icache_flush = 1;
            @(negedge clk);
            icache_flush = 0;
            repeat (NL + 2) @(negedge clk);
            for (int i = 0; i < NL; i++) mv[i] = 0;
         end
         if ($urandom_range(0, 9) == 0)
            a = 34'h0_1000_0000 + 34'($urandom_range(0, 15)) * 4;
         else
            a = BASE + 34'($urandom_range(0, 255)) * 4;
         a[1:0] = 2'($urandom_range(0, 3));
         k = $urandom_range(0, 9);
         instr = (k < 6) ? 1'b1 : (k < 8) ? 1'b0 : 1'($urandom_range(0, 1));
         ws = (k < 8) ? 4'h0 : 4'($urandom_range(1, 15));
         wd = $urandom;
         d = $urandom_range(0, 3);
         fi = ($urandom_range(0, 9) == 0);
         resp_delay = d;
         inject_fault = fi;
         wa = a[33:2];
         li = int'(wa % NL);
         do_fetch = instr && ws == 4'h0 && ((a & MASK) == BASE);
         if (do_fetch && mv[li] && mline[li] == wa) begin
            e_tx = 0; e_lat = 1; e_rd = mdat[li]; e_flt = 0;
         end else if (do_fetch) begin
            e_tx = 1; e_lat = 3 + d; e_rd = rd_mem(wa); e_flt = fi;
            if (!fi) begin mv[li] = 1; mline[li] = wa; mdat[li] = e_rd; end
         end else begin
            e_tx = 1; e_lat = 2 + d; e_rd = rd_mem(wa); e_flt = fi;
            if (ws != 4'h0 && mv[li] && mline[li] == wa) mv[li] = 0;
         end
         do_req(instr, a, ws, wd, rd, flt, lat, tx, tmo, ex);
         inject_fault = 0;
         checks++; if (tmo) begin errors++; $display("FAIL rnd_timeout[%0d] addr=%h got=timeout exp=ready", it, a); end
         checks++; if (tx !== e_tx) begin errors++; $display("FAIL rnd_txns[%0d] addr=%h got=%0d exp=%0d", it, a, tx, e_tx); end
         checks++; if (lat !== e_lat) begin errors++; $display("FAIL rnd_latency[%0d] addr=%h got=%0d exp=%0d", it, a, lat, e_lat); end
         checks++; if (flt !== e_flt) begin errors++; $display("FAIL rnd_fault[%0d] addr=%h got=%b exp=%b", it, a, flt, e_flt); end
         checks++; if (ex !== 1'b0) begin errors++; $display("FAIL rnd_single_ready[%0d] got=%b exp=0", it, ex); end
         if (ws == 4'h0 && !e_flt) begin
            checks++; if (rd !== e_rd) begin errors++; $display("FAIL rnd_rdata[%0d] addr=%h got=%h exp=%h", it, a, rd, e_rd); end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_cold_fetch();
      test_load_bypass();
      test_store_invalidate();
      test_uncacheable_fault();
      test_flush_during_refill();
      test_conflict();
      test_reset_mid_refill();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
